// File: rtl/mpadd_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package mpadd_pkg;

  // Native width of the shared ripple-carry adder.
  localparam int LIMB_W = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Limb counter width. A single-limb build still needs a 1-bit counter.
  function automatic int cnt_width(input int limbs);
    return (limbs <= 1) ? 1 : $clog2(limbs);
  endfunction

endpackage

// File: rtl/fulladder32.sv
// Ripple-carry adder, BITS wide, with carry-in and carry-out.
module fulladder32 #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] s,
  output logic            cout
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i < BITS; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mpadd_seq.sv
// Multi-precision add sequencer: one shared WIDTH-bit adder processes
// LIMBS limbs, LSB first, with the carry held in a register between limbs.
// Optional macro MPADD_SEQ_SUB_EN adds a 'sub' port for A-B.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int WIDTH = LIMB_W,
  parameter int LIMBS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*LIMBS-1:0] A,
  input  logic [WIDTH*LIMBS-1:0] B,
  input  logic                   Pin,
`ifdef MPADD_SEQ_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LIMBS-1:0] S,
  output logic                   Pout,
  output logic                   busy
);

  localparam int TOT_W = WIDTH * LIMBS;
  localparam int CNT_W = cnt_width(LIMBS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMBS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TOT_W-1:0] a_r;
  logic [TOT_W-1:0] b_r;
  logic [TOT_W-1:0] s_r;
  logic             carry_r;

  logic [WIDTH-1:0] a_limb;
  logic [WIDTH-1:0] b_limb;
  logic [WIDTH-1:0] sum_limb;
  logic             sum_cout;
  logic             accept;
  logic             op_sub;

`ifdef MPADD_SEQ_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign S         = s_r;
  assign Pout      = carry_r;

  // Select the operand limbs addressed by the limb counter.
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int i = 0; i < LIMBS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_limb = a_r[i*WIDTH +: WIDTH];
        b_limb = b_r[i*WIDTH +: WIDTH];
      end
    end
  end

  fulladder32 #(
    .BITS(WIDTH)
  ) u_add (
    .a   (a_limb),
    .b   (b_limb),
    .cin (carry_r),
    .s   (sum_limb),
    .cout(sum_cout)
  );

  // Sequencer: capture operands, step one limb per cycle, hold result until taken.
  // Subtraction stores ~B and forces carry-in to 1 (two's complement negate).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= A;
            b_r     <= op_sub ? ~B : B;
            carry_r <= op_sub ? 1'b1 : Pin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < LIMBS; i++) begin
            if (cnt == CNT_W'(i)) begin
              s_r[i*WIDTH +: WIDTH] <= sum_limb;
            end
          end
          carry_r <= sum_cout;
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
